// File: rtl/light_level_ctrl.sv
// Brightness controller: press-once up/down/off buttons step an N-level register that drives a glitch-free PWM.
// Optional feature macro LIGHT_LEVEL_MEMORY_EN: "up" from off restores the level that was active when "off" was pressed.
module light_level_ctrl #(
    parameter int LEVELS      = 5,
    parameter int STEP_CYCLES = 4,
    parameter int LEVEL_W     = $clog2(LEVELS)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [2:0]         i_button,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_on,
    output logic               o_pwm
);
    localparam int PERIOD = (LEVELS - 1) * STEP_CYCLES;
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(LEVELS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   STEP      = CNT_W'(STEP_CYCLES);

    logic [2:0]         r_btn_prev;
    logic [2:0]         w_press;
    logic [LEVEL_W-1:0] r_level;
    logic [LEVEL_W-1:0] w_level_next;
    logic [CNT_W-1:0]   r_pwm_cnt;
    logic [CNT_W-1:0]   r_duty;
    logic               r_pwm;

    // Previous samples reset to 0, so a button held through reset release counts as one press.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_btn_prev <= 3'b000;
        end else begin
            r_btn_prev <= i_button;
        end
    end

    assign w_press = i_button & ~r_btn_prev;

`ifdef LIGHT_LEVEL_MEMORY_EN
    logic [LEVEL_W-1:0] r_saved;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_saved <= '0;
        end else if (w_press[2] && (r_level != '0)) begin
            r_saved <= r_level;
        end
    end
`endif

    // One action per cycle, priority off > down > up; both ends saturate.
    always_comb begin
        w_level_next = r_level;
        if (w_press[2]) begin
            w_level_next = '0;
        end else if (w_press[1]) begin
            if (r_level != '0) begin
                w_level_next = r_level - LEVEL_W'(1);
            end
        end else if (w_press[0]) begin
            if (r_level == '0) begin
`ifdef LIGHT_LEVEL_MEMORY_EN
                w_level_next = (r_saved != '0) ? r_saved : LEVEL_W'(1);
`else
                w_level_next = LEVEL_W'(1);
`endif
            end else if (r_level != LEVEL_MAX) begin
                w_level_next = r_level + LEVEL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    // Duty is only reloaded on the last count, so a period in progress is never truncated.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_pwm <= (r_pwm_cnt < r_duty);
            if (r_pwm_cnt == CNT_LAST) begin
                r_pwm_cnt <= '0;
                r_duty    <= CNT_W'(r_level) * STEP;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_on    = (r_level != '0);
    assign o_pwm   = r_pwm;

endmodule

// File: tb/tb_light_level_ctrl.sv
// Scoreboard bench for light_level_ctrl: the driver queues expected level/PWM values tagged with the
// clock edge they apply to; the monitor compares them on the following falling edge.
module tb_light_level_ctrl;
    localparam int LEVELS = 5;
    localparam int STEP   = 4;
    localparam int PERIOD = 16;
    localparam int LW     = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    btn   = 3'b000;
    logic [LW-1:0] level;
    logic          on;
    logic          pwm;

    light_level_ctrl #(
        .LEVELS      (LEVELS),
        .STEP_CYCLES (STEP)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_button  (btn),
        .o_level   (level),
        .o_on      (on),
        .o_pwm     (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    kind;   // 0: level/on, 1: pwm
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   rst_base = 0;
    bit   drain_timeout = 1'b0;
    bit   timeout_seen = 1'b0;

    logic [LW-1:0] m_lvl;
    logic          m_on;
    logic          m_pwm;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation that belongs to the edge just taken.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_vec++;
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                             sb[i].name, sb[i].cyc, cyc);
                end else if (sb[i].kind == 0) begin
                    m_lvl = sb[i].val[LW-1:0];
                    m_on  = (sb[i].val != 0);
                    if (level !== m_lvl || on !== m_on) begin
                        n_err++;
                        $display("FAIL %s @cyc %0d: level=%0d on=%0b, expected level=%0d on=%0b",
                                 sb[i].name, cyc, level, on, m_lvl, m_on);
                    end else begin
                        $display("cyc %0d %s: level=%0d on=%0b ok", cyc, sb[i].name, level, on);
                    end
                end else begin
                    m_pwm = sb[i].val[0];
                    if (pwm !== m_pwm) begin
                        n_err++;
                        $display("FAIL %s @cyc %0d: pwm=%0b, expected %0b", sb[i].name, cyc, pwm, m_pwm);
                    end else begin
                        $display("cyc %0d %s: pwm=%0b ok", cyc, sb[i].name, pwm);
                    end
                end
                sb.delete(i);
            end
        end
        if (drain_timeout && !timeout_seen) begin
            timeout_seen = 1'b1;
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left after cycle budget, expected 0", sb.size());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int c, input int kind, input int val, input string name);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Button vector held for exactly one sampling edge, then released for one edge.
    task automatic press(input logic [2:0] v, input int exp_lvl, input string name);
        btn = v;
        push(cyc + 1, 0, exp_lvl, name);
        tick();
        btn = 3'b000;
        tick();
    endtask

    task automatic hold_up(input int exp_lvl, input string name);
        btn = 3'b001;
        for (int i = 0; i < 10; i++) begin
            push(cyc + 1, 0, exp_lvl, name);
            tick();
        end
        btn = 3'b000;
        tick();
    endtask

    // Return with inputs about to be sampled at edge k (edges counted from reset release).
    task automatic wait_next(input int k);
        while ((cyc - rst_base) < k - 1) tick();
    endtask

    // Window m covers edges 16m+1 .. 16m+16; duty given in on-cycles.
    task automatic pwm_window(input int m, input int duty, input string name);
        for (int i = 0; i < PERIOD; i++) begin
            push(rst_base + PERIOD * m + 1 + i, 1, (i < duty) ? 1 : 0, name);
        end
    endtask

    initial begin
        int m;
        int mem_exp;

        tick();
        push(cyc, 0, 0, "reset_level");
        push(cyc, 1, 0, "reset_pwm");
        tick();
        rst_n = 1'b1;
        rst_base = cyc;

        press(3'b001, 1, "up1");
        press(3'b001, 2, "up2");
        press(3'b001, 3, "up3");
        press(3'b001, 4, "up4");
        press(3'b001, 4, "up_sat");

        press(3'b100, 0, "off");
        press(3'b001, 1, "up_from_0");
        hold_up(2, "hold_up_at1");
        press(3'b001, 3, "up3b");
        hold_up(4, "hold_up_at3");
        press(3'b010, 3, "down1");
        press(3'b010, 2, "down2");
        press(3'b010, 1, "down3");
        press(3'b010, 0, "down4");
        press(3'b010, 0, "down_sat1");
        press(3'b010, 0, "down_sat2");

        press(3'b001, 1, "up_a");
        press(3'b001, 2, "up_b");
        press(3'b001, 3, "up_c");
        press(3'b111, 0, "all_three");
        press(3'b001, 1, "up_d");
        press(3'b001, 2, "up_e");
        press(3'b011, 1, "up_and_down");

        press(3'b001, 2, "to_level2");
        m = (cyc - rst_base) / PERIOD + 1;
        pwm_window(m, 8, "pwm_lvl2");
        pwm_window(m + 1, 12, "pwm_lvl3");
        pwm_window(m + 2, 12, "pwm_boundary_old");
        pwm_window(m + 3, 16, "pwm_lvl4");
        pwm_window(m + 4, 0, "pwm_lvl0");
        wait_next(PERIOD * m + 5);
        press(3'b001, 3, "mid_period_up");
        wait_next(PERIOD * (m + 2));
        press(3'b001, 4, "boundary_up");
        wait_next(PERIOD * (m + 3) + 3);
        press(3'b100, 0, "off_in_lvl4");
        wait_next(PERIOD * (m + 5) + 2);

        press(3'b001, 1, "up_r1");
        press(3'b001, 2, "up_r2");
        press(3'b001, 3, "up_r3");
        m = (cyc - rst_base) / PERIOD + 2;
        wait_next(PERIOD * m + 4);
        push(cyc, 0, 3, "pre_reset_level");
        push(cyc, 1, 1, "pre_reset_pwm");
        tick();
        rst_n = 1'b0;
        push(cyc, 0, 0, "async_reset_level");
        push(cyc, 1, 0, "async_reset_pwm");
        btn = 3'b001;
        tick();
        rst_n = 1'b1;
        rst_base = cyc;
        push(cyc + 1, 0, 1, "up_through_reset");
        pwm_window(0, 0, "pwm_after_reset");
        tick();
        btn = 3'b000;
        tick();

`ifdef LIGHT_LEVEL_MEMORY_EN
        mem_exp = 3;
`else
        mem_exp = 1;
`endif
        press(3'b001, 2, "mem_up2");
        press(3'b001, 3, "mem_up3");
        press(3'b100, 0, "mem_off");
        press(3'b001, mem_exp, "mem_restore");

        for (int i = 0; i < 2000 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) drain_timeout = 1'b1;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
